// File: rtl/seq_mag_comparator_if.sv
// Operand/result handshake bundle for seq_mag_comparator.
// The master side supplies operands and accepts results; the slave side is the comparator.
interface seq_mag_comparator_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             signed_mode;
   logic             out_valid;
   logic             out_ready;
   logic             a_big;
   logic             b_big;
   logic             a_b;

   modport master (
      output in_valid, a, b, signed_mode, out_ready,
      input  in_ready, out_valid, a_big, b_big, a_b
   );

   modport slave (
      input  in_valid, a, b, signed_mode, out_ready,
      output in_ready, out_valid, a_big, b_big, a_b
   );
endinterface

// File: rtl/seq_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator, CHUNK bits per cycle, unsigned or two's-complement.
// Optional macro CMP_EARLY_EXIT_EN: finish on the first differing chunk instead of always scanning all chunks.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// CMP   | scanning chunks from MSB down, decision frozen at first difference
// DONE  | result presented, out_valid high until consumer accepts
module seq_mag_comparator #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   seq_mag_comparator_if.slave bus
);
   localparam int NCH = WIDTH / CHUNK;
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             signed_q;
   logic [IW-1:0]    idx;
   logic             dec_gt;
   logic             dec_lt;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             a_big_q;
   logic             b_big_q;
   logic             a_b_q;

   logic [WIDTH-1:0] msb_flip;
   logic [WIDTH-1:0] a_adj;
   logic [WIDTH-1:0] b_adj;
   logic [CHUNK-1:0] a_ch;
   logic [CHUNK-1:0] b_ch;
   logic             nxt_gt;
   logic             nxt_lt;
   logic             stop;

   // Flipping the sign bit on both sides maps two's-complement order onto unsigned order;
   // the sign bit only lives in the MSB chunk, so the flip is harmless elsewhere.
   always_comb begin
      msb_flip            = '0;
      msb_flip[WIDTH-1]   = signed_q;
      a_adj               = a_q ^ msb_flip;
      b_adj               = b_q ^ msb_flip;
      a_ch                = a_adj[int'(idx) * CHUNK +: CHUNK];
      b_ch                = b_adj[int'(idx) * CHUNK +: CHUNK];
      nxt_gt              = dec_gt | (~dec_lt & (a_ch > b_ch));
      nxt_lt              = dec_lt | (~dec_gt & (a_ch < b_ch));
`ifdef CMP_EARLY_EXIT_EN
      stop                = (idx == '0) | nxt_gt | nxt_lt;
`else
      stop                = (idx == '0);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         signed_q    <= 1'b0;
         idx         <= '0;
         dec_gt      <= 1'b0;
         dec_lt      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         a_big_q     <= 1'b0;
         b_big_q     <= 1'b0;
         a_b_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (bus.in_valid && in_ready_q) begin
                  a_q        <= bus.a;
                  b_q        <= bus.b;
                  signed_q   <= bus.signed_mode;
                  idx        <= LAST_IDX;
                  dec_gt     <= 1'b0;
                  dec_lt     <= 1'b0;
                  in_ready_q <= 1'b0;
                  state      <= CMP;
               end
            end
            CMP: begin
               dec_gt <= nxt_gt;
               dec_lt <= nxt_lt;
               if (stop) begin
                  out_valid_q <= 1'b1;
                  a_big_q     <= nxt_gt;
                  b_big_q     <= nxt_lt;
                  a_b_q       <= ~(nxt_gt | nxt_lt);
                  state       <= DONE;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  a_big_q     <= 1'b0;
                  b_big_q     <= 1'b0;
                  a_b_q       <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.a_big     = a_big_q;
   assign bus.b_big     = b_big_q;
   assign bus.a_b       = a_b_q;
endmodule
